// File: rtl/led_pattern_seq_if.sv
// Control/status bundle between an LED demo controller (master) and led_pattern_seq (slave).
interface led_pattern_seq_if #(
  parameter int unsigned LED_BITS = 16
) ();
  logic [1:0]          mode;
  logic [1:0]          speed;
  logic                pause;
  logic [LED_BITS-1:0] led;
  logic                step;
  logic                dir;

  modport master (output mode, speed, pause, input led, step, dir);
  modport slave  (input mode, speed, pause, output led, step, dir);
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: prescaler-timed rotate / bounce / fill-drain / count engine.
// Define LED_SEQ_GRAY_EN to show the count mode as Gray code instead of binary.
module led_pattern_seq #(
  parameter int unsigned LED_BITS      = 16,
  parameter int unsigned PRESCALE_BITS = 21
) (
  input  logic             clk,
  input  logic             rst,
  led_pattern_seq_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  localparam logic [PRESCALE_BITS-1:0] CNT_ONES = '1;
  localparam logic [LED_BITS-1:0]      LED_SEED = LED_BITS'(1);

  mode_e                    mode_q, mode_d;
  logic [PRESCALE_BITS-1:0] cnt_q, cnt_d;
  logic [LED_BITS-1:0]      led_q, led_d;
  logic [LED_BITS-1:0]      bin_q, bin_d;
  logic                     dir_q, dir_d;
  logic                     step_q, step_d;
  logic                     fill_q, fill_d;

  mode_e                    mode_in;
  logic [PRESCALE_BITS-1:0] term_mask;
  logic                     terminal;
  logic                     mode_chg;
  logic                     fill_bit;
  logic [LED_BITS-1:0]      led_shl, led_shr;

  function automatic logic [LED_BITS-1:0] seed_of(input mode_e m);
    return ((m == MODE_ROTATE) || (m == MODE_BOUNCE)) ? LED_SEED : '0;
  endfunction

  function automatic logic [LED_BITS-1:0] count_view(input logic [LED_BITS-1:0] b);
`ifdef LED_SEQ_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  assign mode_in   = mode_e'(bus.mode);
  assign mode_chg  = (mode_in != mode_q);
  // Only the low (PRESCALE_BITS - speed) bits take part in the terminal test.
  assign term_mask = CNT_ONES >> bus.speed;
  assign terminal  = &(cnt_q | ~term_mask);
  assign led_shl   = led_q << 1;
  assign led_shr   = led_q >> 1;

  always_comb begin
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    bin_d    = bin_q;
    dir_d    = dir_q;
    fill_d   = fill_q;
    step_d   = 1'b0;
    fill_bit = fill_q;

    if (mode_chg) begin
      mode_d = mode_in;
      cnt_d  = '0;
      led_d  = seed_of(mode_in);
      bin_d  = '0;
      dir_d  = 1'b0;
      fill_d = 1'b1;
    end else if (!bus.pause) begin
      cnt_d = cnt_q + PRESCALE_BITS'(1);
      if (terminal) begin
        step_d = 1'b1;
        unique case (mode_q)
          MODE_ROTATE: led_d = {led_q[LED_BITS-2:0], led_q[LED_BITS-1]};
          MODE_BOUNCE: begin
            // Direction flips on the step that lands on an end bit.
            if (!dir_q) begin
              led_d = led_shl;
              dir_d = led_shl[LED_BITS-1];
            end else begin
              led_d = led_shr;
              dir_d = !led_shr[0];
            end
          end
          MODE_FILL: begin
            fill_bit = fill_q ? !led_q[LED_BITS-1] : (led_q == '0);
            led_d    = {led_q[LED_BITS-2:0], fill_bit};
            fill_d   = fill_bit;
            dir_d    = !fill_bit;
          end
          MODE_COUNT: begin
            bin_d = bin_q + LED_BITS'(1);
            led_d = count_view(bin_q + LED_BITS'(1));
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_ROTATE;
      cnt_q  <= '0;
      led_q  <= LED_SEED;
      bin_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      fill_q <= 1'b1;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      bin_q  <= bin_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      fill_q <= fill_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.step = step_q;
  assign bus.dir  = dir_q;

endmodule
